mem_port_arbiter: RTL and testbench

Shares the single-port synchronous program/data RAM between two requesters: the CPU control FSM (fetch, LOAD, STOR) and the video scan-out reader (read-only).
- Serialises accesses and returns read data with a one-cycle ack pulse.
- The CPU FSM holds its request and stalls until ack.
- Sits between the datapath/controller and the memory macro.
- Video has priority, with a bounded-starvation guard for the CPU.

---
 rtl/mem_arb_pkg.sv | 37 +++
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and winner pick for the RAM port arbiter
package mem_arb_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_ACCESS = ACCESS,
        ST_RESP   = RESP
    } arb_state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_VID = 1'b1;

    // Video wins unless the CPU has waited out a full streak; urgency beats the guard.
    function automatic logic pick_owner(
        input logic cpu_req,
        input logic vid_req,
        input logic vid_urgent,
        input logic streak_full
    );
        logic owner;
        if (vid_req && vid_urgent) begin
            owner = OWN_VID;
        end else if (vid_req && cpu_req && streak_full) begin
            owner = OWN_CPU;
        end else if (vid_req) begin
            owner = OWN_VID;
        end else begin
            owner = OWN_CPU;
        end
        return owner;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for the single-port program/data RAM
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int MAX_VID_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_ack_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              vid_req_i,
    input  logic              vid_urgent_i,
    input  logic [ADDR_W-1:0] vid_addr_i,
    output logic              vid_ack_o,
    output logic [DATA_W-1:0] vid_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    localparam int                  STREAK_W   = $clog2(MAX_VID_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_VID_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

    arb_state_e          state_q, state_d;
    logic                owner_q, owner_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_CPU;
            streak_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant       = pick_owner(cpu_req_i, vid_req_i, vid_urgent_i, streak_q == STREAK_MAX);

        case (state_q)
            ST_IDLE: begin
                if (cpu_req_i || vid_req_i) begin
                    owner_d  = grant;
                    mem_en_d = 1'b1;
                    state_d  = ST_ACCESS;
                    if (grant == OWN_CPU) begin
                        mem_we_d    = cpu_we_i;
                        mem_addr_d  = cpu_addr_i;
                        mem_wdata_d = cpu_wdata_i;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = vid_addr_i;
                        mem_wdata_d = '0;
                    end
                    // The streak only measures video grants taken while the CPU was waiting.
                    if (!cpu_req_i || grant == OWN_CPU) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + STREAK_ONE;
                    end
                end
            end
            ST_ACCESS: begin
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign cpu_ack_o   = (state_q == ST_RESP) && (owner_q == OWN_CPU);
    assign vid_ack_o   = (state_q == ST_RESP) && (owner_q == OWN_VID);
    assign cpu_rdata_o = cpu_ack_o ? mem_rdata_i : '0;
    assign vid_rdata_o = vid_ack_o ? mem_rdata_i : '0;

    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        vid_req = 1'b0, vid_urgent = 1'b0;
    logic [15:0] vid_addr = '0;
    logic        vid_ack;
    logic [15:0] vid_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        busy;

    logic [15:0] ram [0:65535];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    string       grant_log = "";

    typedef struct {
        logic        chk;
        logic [15:0] data;
    } exp_t;
    exp_t cpu_q[$];
    exp_t vid_q[$];

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_VID_STREAK(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata),
        .vid_req_i(vid_req), .vid_urgent_i(vid_urgent), .vid_addr_i(vid_addr),
        .vid_ack_o(vid_ack), .vid_rdata_o(vid_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    function automatic logic [15:0] pre(input logic [15:0] a);
        return a ^ 16'h3C3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
        end
    endtask

    // Scoreboard side: pop one expectation per observed ack.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (cpu_ack || vid_ack)) begin
            check("ack_exclusive", {31'd0, cpu_ack & vid_ack}, 32'd0);
            if (cpu_ack) begin
                grant_log = {grant_log, "C"};
                if (cpu_q.size() == 0) check("cpu_ack_expected", 32'd0, 32'd1);
                else begin
                    e = cpu_q.pop_front();
                    if (e.chk) check("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, e.data});
                end
            end
            if (vid_ack) begin
                grant_log = {grant_log, "V"};
                if (vid_q.size() == 0) check("vid_ack_expected", 32'd0, 32'd1);
                else begin
                    e = vid_q.pop_front();
                    check("vid_rdata", {16'd0, vid_rdata}, {16'd0, e.data});
                end
            end
        end
    end

    task automatic wait_ack(input logic is_vid, input string name, output int at);
        logic seen;
        seen = 1'b0;
        at   = -1;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (is_vid ? vid_ack : cpu_ack) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic cpu_txn(input vec_t v, input int idx);
        int t0;
        t0 = cyc;
        cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        cpu_q.push_back('{chk: !v.we, data: v.rdata});
        @(negedge clk);
        check($sformatf("v%0d_idle_busy", idx), {31'd0, busy}, 32'd0);
        check($sformatf("v%0d_idle_en", idx), {31'd0, mem_en}, 32'd0);
        @(negedge clk);
        check($sformatf("v%0d_acc_en", idx), {31'd0, mem_en}, 32'd1);
        check($sformatf("v%0d_acc_we", idx), {31'd0, mem_we}, {31'd0, v.we});
        check($sformatf("v%0d_acc_addr", idx), {16'd0, mem_addr}, {16'd0, v.addr});
        if (v.we) check($sformatf("v%0d_acc_wdata", idx), {16'd0, mem_wdata}, {16'd0, v.wdata});
        @(negedge clk);
        check($sformatf("v%0d_resp_ack_cyc", idx), {31'd0, cpu_ack}, 32'd1);
        check($sformatf("v%0d_resp_vid_ack", idx), {31'd0, vid_ack}, 32'd0);
        check($sformatf("v%0d_resp_en_we", idx), {30'd0, mem_en, mem_we}, 32'd0);
        check($sformatf("v%0d_ack_latency", idx), cyc - t0, 32'd2);
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic hold_vid(input int n, input int urgent_n, input logic [15:0] addr, output int last);
        int at;
        last = -1;
        vid_req = 1'b1; vid_addr = addr; vid_urgent = (urgent_n > 0);
        for (int k = 0; k < n; k++) begin
            vid_q.push_back('{chk: 1'b1, data: pre(addr)});
            wait_ack(1'b1, "vid_ack", at);
            last = at;
            if (k + 1 == urgent_n && k != n - 1) begin
                @(posedge clk); #1;
                vid_urgent = 1'b0;
            end
        end
        @(posedge clk); #1;
        vid_req = 1'b0; vid_urgent = 1'b0;
    endtask

    task automatic hold_cpu(input logic [15:0] addr, output int last);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
        cpu_q.push_back('{chk: 1'b1, data: pre(addr)});
        wait_ack(1'b0, "cpu_ack", last);
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic start_test();
        cpu_q.delete();
        vid_q.delete();
        grant_log = "";
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int t0, vlast, clast;

        for (int i = 0; i < 65536; i++) ram[i] = pre(16'(i));
        ram[16'h0010] = 16'hBEEF;

        vecs[0] = '{we: 1'b0, addr: 16'h0010, wdata: 16'h0000, rdata: 16'hBEEF};
        vecs[1] = '{we: 1'b1, addr: 16'h0020, wdata: 16'h1234, rdata: 16'h0000};
        vecs[2] = '{we: 1'b0, addr: 16'h0020, wdata: 16'h0000, rdata: 16'h1234};
        vecs[3] = '{we: 1'b1, addr: 16'hFFFF, wdata: 16'hA5A5, rdata: 16'h0000};
        vecs[4] = '{we: 1'b0, addr: 16'hFFFF, wdata: 16'h0000, rdata: 16'hA5A5};
        vecs[5] = '{we: 1'b0, addr: 16'h0000, wdata: 16'h0000, rdata: 16'h3C3C};

        repeat (3) @(negedge clk);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        check("rst_acks", {30'd0, cpu_ack, vid_ack}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // CPU alone: single read, write-then-read back to back, boundary address
        for (int i = 0; i < 6; i++) cpu_txn(vecs[i], i);

        // Simultaneous requests: video first, CPU on the next slot
        start_test();
        t0 = cyc;
        fork
            hold_vid(1, 0, 16'h8000, vlast);
            hold_cpu(16'h0100, clast);
            begin
                @(negedge clk); @(negedge clk);
                check("t3_acc_addr", {16'd0, mem_addr}, 32'h8000);
                check("t3_acc_we", {31'd0, mem_we}, 32'd0);
            end
        join
        check("t3_vid_ack_cyc", vlast - t0, 32'd2);
        check("t3_cpu_ack_cyc", clast - t0, 32'd5);
        check_str("t3_order", grant_log, "VC");

        // Both held: guard forces the CPU in after four video grants
        start_test();
        t0 = cyc;
        fork
            hold_vid(5, 0, 16'h8002, vlast);
            hold_cpu(16'h0102, clast);
        join
        check("t4_cpu_ack_cyc", clast - t0, 32'd14);
        check_str("t4_order", grant_log, "VVVVCV");

        // Urgent video overrides the guard until video lets go
        start_test();
        t0 = cyc;
        fork
            hold_vid(6, 6, 16'h8004, vlast);
            hold_cpu(16'h0104, clast);
        join
        check("t5_cpu_ack_cyc", clast - t0, 32'd20);
        check_str("t5_order", grant_log, "VVVVVVC");

        // Urgency drops but video stays: streak saturated, so CPU wins at once
        start_test();
        t0 = cyc;
        fork
            hold_vid(7, 6, 16'h8006, vlast);
            hold_cpu(16'h0106, clast);
        join
        check("t5b_cpu_ack_cyc", clast - t0, 32'd20);
        check("t5b_vid_last_cyc", vlast - t0, 32'd23);
        check_str("t5b_order", grant_log, "VVVVVVCV");

        // Async reset during ACCESS of a CPU write
        start_test();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'hDEAD;
        @(negedge clk);
        @(negedge clk);
        check("t6_acc_en_we", {30'd0, mem_en, mem_we}, 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_en_we", {30'd0, mem_en, mem_we}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_acks", {30'd0, cpu_ack, vid_ack}, 32'd0);
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        check("t6_no_ack", {30'd0, cpu_ack, vid_ack}, 32'd0);
        #2;
        reset = 1'b0;
        @(posedge clk); #1;
        cpu_txn('{we: 1'b0, addr: 16'h0050, wdata: 16'h0000, rdata: pre(16'h0050)}, 6);

        repeat (3) @(posedge clk);
        check("final_cpu_q_empty", cpu_q.size(), 32'd0);
        check("final_vid_q_empty", vid_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
